// File: rtl/operand_entry.sv
// ----------------------------------------------------------------------------
// operand_entry
//   Keypad-style operand entry for the calculator. It is the input-side
//   counterpart of the BCD display path.
//   - The raw pushbuttons are synchronised and debounced. Each key has its own
//     debouncer, built as an array of operand_entry_key_db instances.
//   - Decimal digits come from the switches and are shifted into a BCD echo
//     register.
//   - On enter, the BCD value is converted to binary one bit per cycle
//     (reverse double-dabble).
//   - The magnitude is then range-checked and published as an unsigned or
//     two's complement operand, with a one-cycle valid pulse.
//
// Parameters
//   width     operand width in bits
//   digits    number of BCD digits accepted (binary register is 4*digits bits)
//   db_cycles consecutive stable cycles needed to accept a key level change
//
// Ports
//   clk            system clock, rising edge
//   rst_n          synchronous reset, active low
//   sw_digit[3:0]  BCD digit from switches, sampled on a digit-key press
//   key_n[3:0]     raw pushbuttons, active low:
//                  [0] digit, [1] sign toggle, [2] enter, [3] clear
//   sgn            1 = signed entry/range, 0 = unsigned
//   operand        last accepted operand (registered)
//   operand_valid  one-cycle pulse when operand is updated
//   bcd_echo       entered digits, newest digit in [3:0]
//   neg            current sign flag
//   entry_err      range error; sticky until clear or the next enter
//   busy           high while converting (CONV and DONE)
//
// Configuration
//   ENTRY_SATURATE_EN : an out-of-range magnitude saturates to the nearest
//                       limit. The operand still updates and valid still
//                       pulses; entry_err is also raised. When undefined,
//                       an out-of-range value is rejected and operand keeps
//                       its old value.
// ----------------------------------------------------------------------------

// One key: 2-FF synchroniser plus a stable-level counter.
// press pulses for one cycle when the debounced level goes released -> pressed.
module operand_entry_key_db #(
    parameter int DB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw_n,
    output logic press
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          s1, s2, lvl;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            lvl   <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            s1    <= key_raw_n;
            s2    <= s1;
            press <= 1'b0;
            // Any cycle that agrees with the accepted level restarts the run.
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                lvl   <= s2;
                cnt   <= '0;
                press <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module operand_entry #(
    parameter int width     = 6,
    parameter int digits    = 2,
    parameter int db_cycles = 250000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            sw_digit,
    input  logic [3:0]            key_n,
    input  logic                  sgn,
    output logic [width-1:0]      operand,
    output logic                  operand_valid,
    output logic [4*digits-1:0]   bcd_echo,
    output logic                  neg,
    output logic                  entry_err,
    output logic                  busy
);
    localparam int BW   = 4 * digits;
    localparam int CNTW = $clog2(BW);
    // Range math is done one bit wider than the larger of width and BW,
    // so the limits never overflow.
    localparam int MW   = ((width > BW) ? width : BW) + 1;

    typedef enum logic [1:0] {ENTRY, CONV, DONE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        press;
    logic              ev_clr, ev_ent, ev_dig, ev_sgn;
    logic [2*BW-1:0]   sr, sr_shift;
    logic [CNTW-1:0]   cnt;
    logic              last_conv;
    logic [MW-1:0]     mag, lim;
    logic [width-1:0]  magw, res;
    logic              neg_eff, in_range;
`ifdef ENTRY_SATURATE_EN
    logic [width-1:0]  sat;
`endif

    operand_entry_key_db #(.DB_CYCLES(db_cycles)) u_db [3:0] (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_raw_n (key_n),
        .press     (press)
    );

    // Same-cycle priority: clear > enter > digit > sign.
    assign ev_clr = press[3];
    assign ev_ent = press[2] & ~press[3];
    assign ev_dig = press[0] & ~press[2] & ~press[3];
    assign ev_sgn = press[1] & ~press[0] & ~press[2] & ~press[3];

    assign last_conv = (state == CONV) && (cnt == CNTW'(BW - 1));
    assign busy      = (state != ENTRY);

    // One reverse double-dabble step: shift {bcd,bin} right,
    // then take 3 off every BCD nibble that is now >= 8.
    always_comb begin
        sr_shift = sr >> 1;
        for (int i = 0; i < digits; i++) begin
            if (sr_shift[BW+4*i +: 4] >= 4'd8)
                sr_shift[BW+4*i +: 4] = sr_shift[BW+4*i +: 4] - 4'd3;
        end
    end

    // The range check looks at the value the final shift produces. That lets
    // operand and operand_valid be registered on the way into DONE, so both
    // line up with the DONE cycle.
    always_comb begin
        mag     = MW'(sr_shift[BW-1:0]);
        magw    = mag[width-1:0];
        neg_eff = sgn & neg;
        if (!sgn)     lim = (MW'(1) << width) - MW'(1);
        else if (neg) lim = MW'(1) << (width - 1);
        else          lim = (MW'(1) << (width - 1)) - MW'(1);
        in_range = (mag <= lim);
        res      = neg_eff ? -magw : magw;
`ifdef ENTRY_SATURATE_EN
        sat      = neg_eff ? -lim[width-1:0] : lim[width-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ENTRY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ENTRY:   if (ev_ent) state_nxt = CONV;
            CONV:    if (last_conv) state_nxt = DONE;
            DONE:    state_nxt = ENTRY;
            default: state_nxt = ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            operand       <= '0;
            operand_valid <= 1'b0;
            bcd_echo      <= '0;
            neg           <= 1'b0;
            entry_err     <= 1'b0;
            sr            <= '0;
            cnt           <= '0;
        end else begin
            operand_valid <= 1'b0;
            case (state)
                // Key events are acted on only here; during CONV/DONE they
                // are dropped, not queued.
                ENTRY: begin
                    if (ev_clr) begin
                        bcd_echo  <= '0;
                        neg       <= 1'b0;
                        entry_err <= 1'b0;
                    end else if (ev_ent) begin
                        entry_err <= 1'b0;
                        sr        <= {bcd_echo, BW'(0)};
                        cnt       <= '0;
                    end else if (ev_dig) begin
                        if (sw_digit <= 4'd9)
                            bcd_echo <= (bcd_echo << 4) | BW'(sw_digit);
                    end else if (ev_sgn) begin
                        if (sgn) neg <= ~neg;
                    end
                end
                CONV: begin
                    sr  <= sr_shift;
                    cnt <= cnt + 1'b1;
                    if (last_conv) begin
`ifdef ENTRY_SATURATE_EN
                        operand       <= in_range ? res : sat;
                        operand_valid <= 1'b1;
                        entry_err     <= ~in_range;
`else
                        if (in_range) begin
                            operand       <= res;
                            operand_valid <= 1'b1;
                        end else begin
                            entry_err <= 1'b1;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_operand_entry.sv
`timescale 1ns/1ps
module tb_operand_entry;
    localparam int W  = 6;
    localparam int D  = 2;
    localparam int DB = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       sw_digit = 4'd0;
    logic [3:0]       key_n = 4'hF;
    logic             sgn = 1'b0;
    logic [W-1:0]     operand;
    logic             operand_valid;
    logic [4*D-1:0]   bcd_echo;
    logic             neg, entry_err, busy;

    operand_entry #(.width(W), .digits(D), .db_cycles(DB)) dut (
        .clk(clk), .rst_n(rst_n), .sw_digit(sw_digit), .key_n(key_n), .sgn(sgn),
        .operand(operand), .operand_valid(operand_valid), .bcd_echo(bcd_echo),
        .neg(neg), .entry_err(entry_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [W-1:0] op; int vcnt; logic err; } exp_t;
    typedef struct { logic s; logic [3:0] hi; logic [3:0] lo; logic sign;
                     logic [W-1:0] op; int vcnt; logic err; } vec_t;

    exp_t sb[$];
    vec_t vec[11];

    int n_chk = 0;
    int n_fail = 0;

    // Conversion monitor, sampled on the falling edge.
    logic         mon_busy_q = 1'b0;
    int           mon_cyc = 0, mon_vcnt = 0, mon_lat = 0;
    int           mon_done = 0, mon_rise = 0, mon_vtot = 0;
    logic [W-1:0] mon_op = '0;
    logic         mon_err = 1'b0;

    always @(negedge clk) begin
        mon_busy_q <= busy;
        if (operand_valid) mon_vtot <= mon_vtot + 1;
        if (busy && !mon_busy_q) begin
            mon_rise <= mon_rise + 1;
            mon_cyc  <= 0;
            mon_vcnt <= operand_valid ? 1 : 0;
            mon_lat  <= 0;
        end else begin
            if (busy) mon_cyc <= mon_cyc + 1;
            if (operand_valid) begin
                mon_vcnt <= mon_vcnt + 1;
                mon_lat  <= mon_cyc + 1;
            end
        end
        if (!busy && mon_busy_q) begin
            mon_op   <= operand;
            mon_err  <= entry_err;
            mon_done <= mon_done + 1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic press(input int k);
        key_n[k] = 1'b0;
        cyc(8);
        key_n[k] = 1'b1;
        cyc(8);
    endtask

    task automatic press_digit(input logic [3:0] d);
        sw_digit = d;
        press(0);
    endtask

    // Wait for the conversion that started after 'base', then score it.
    task automatic wait_done(input string nm, input int base);
        exp_t e;
        int t = 0;
        while (mon_done == base && t < 60) begin
            cyc(1);
            t++;
        end
        if (mon_done == base) begin
            n_chk++; n_fail++;
            $display("FAIL %s: timeout waiting for conversion end", nm);
        end else if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL %s: conversion with no expected result queued", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, " operand"}, 32'(mon_op), 32'(e.op));
            chk({nm, " valid_count"}, mon_vcnt, e.vcnt);
            chk({nm, " entry_err"}, 32'(mon_err), 32'(e.err));
            if (e.vcnt > 0) chk({nm, " latency"}, mon_lat, 8);
        end
    endtask

    initial begin
        int base, rise0, vt0, t;

        // Reset state
        rst_n = 1'b0;
        cyc(3);
        chk("rst operand", 32'(operand), 0);
        chk("rst valid", 32'(operand_valid), 0);
        chk("rst echo", 32'(bcd_echo), 0);
        chk("rst neg", 32'(neg), 0);
        chk("rst err", 32'(entry_err), 0);
        chk("rst busy", 32'(busy), 0);
        rst_n = 1'b1;
        cyc(2);

        // {sgn, hi, lo, sign press, operand, valid pulses, entry_err}
        vec[0] = '{1'b0, 4'd4, 4'd2, 1'b0, 6'd42,  1, 1'b0};
        vec[1] = '{1'b1, 4'd3, 4'd2, 1'b1, 6'h20,  1, 1'b0};
`ifdef ENTRY_SATURATE_EN
        vec[2] = '{1'b1, 4'd3, 4'd2, 1'b0, 6'h1F,  1, 1'b1};
`else
        vec[2] = '{1'b1, 4'd3, 4'd2, 1'b0, 6'h20,  0, 1'b1};
`endif
        vec[3] = '{1'b0, 4'd6, 4'd3, 1'b0, 6'h3F,  1, 1'b0};
`ifdef ENTRY_SATURATE_EN
        vec[4] = '{1'b0, 4'd6, 4'd4, 1'b0, 6'h3F,  1, 1'b1};
`else
        vec[4] = '{1'b0, 4'd6, 4'd4, 1'b0, 6'h3F,  0, 1'b1};
`endif
        vec[5] = '{1'b1, 4'd3, 4'd1, 1'b0, 6'h1F,  1, 1'b0};
        vec[6] = '{1'b1, 4'd0, 4'd5, 1'b1, 6'h3B,  1, 1'b0};
`ifdef ENTRY_SATURATE_EN
        vec[7] = '{1'b1, 4'd3, 4'd3, 1'b1, 6'h20,  1, 1'b1};
        vec[8] = '{1'b0, 4'd9, 4'd9, 1'b0, 6'h3F,  1, 1'b1};
`else
        vec[7] = '{1'b1, 4'd3, 4'd3, 1'b1, 6'h3B,  0, 1'b1};
        vec[8] = '{1'b0, 4'd9, 4'd9, 1'b0, 6'h3B,  0, 1'b1};
`endif
        vec[9]  = '{1'b0, 4'd1, 4'd5, 1'b1, 6'h0F, 1, 1'b0};
        vec[10] = '{1'b0, 4'd0, 4'd0, 1'b0, 6'h00, 1, 1'b0};

        for (int i = 0; i < 11; i++) begin
            sgn = vec[i].s;
            press(3);
            press_digit(vec[i].hi);
            press_digit(vec[i].lo);
            if (vec[i].sign) press(1);
            chk($sformatf("vec%0d echo", i), 32'(bcd_echo), 32'({vec[i].hi, vec[i].lo}));
            chk($sformatf("vec%0d neg", i), 32'(neg), 32'(vec[i].s & vec[i].sign));
            sb.push_back('{op: vec[i].op, vcnt: vec[i].vcnt, err: vec[i].err});
            base = mon_done;
            press(2);
            wait_done($sformatf("vec%0d", i), base);
        end

        // Digit shifting, invalid digit, sign toggling
        sgn = 1'b0;
        press(3);
        press_digit(4'd1);
        press_digit(4'd2);
        press_digit(4'd3);
        chk("oldest digit drops", 32'(bcd_echo), 32'h23);
        press_digit(4'hC);
        chk("digit >9 ignored", 32'(bcd_echo), 32'h23);
        press(1);
        chk("sign ignored sgn=0", 32'(neg), 0);
        sgn = 1'b1;
        press(1);
        chk("sign toggle on", 32'(neg), 1);
        press(1);
        chk("sign toggle off", 32'(neg), 0);
        sgn = 1'b0;

        // Bouncing digit key: only the final stable level counts
        press(3);
        sw_digit = 4'd7;
        for (int i = 0; i < 10; i++) begin
            key_n[0] = ~key_n[0];
            cyc(2);
        end
        chk("bounce no accept", 32'(bcd_echo), 0);
        key_n[0] = 1'b0;
        cyc(10);
        key_n[0] = 1'b1;
        cyc(8);
        chk("bounce one digit", 32'(bcd_echo), 32'h07);

        // Clear and enter in the same cycle: clear wins
        rise0 = mon_rise;
        vt0   = mon_vtot;
        key_n[3] = 1'b0;
        key_n[2] = 1'b0;
        cyc(8);
        key_n = 4'hF;
        cyc(16);
        chk("clr+ent echo", 32'(bcd_echo), 0);
        chk("clr+ent no busy", mon_rise, rise0);
        chk("clr+ent no valid", mon_vtot, vt0);

        // Enter and digit events landing during CONV are dropped
        press_digit(4'd1);
        press_digit(4'd2);
        rise0 = mon_rise;
        vt0   = mon_vtot;
        base  = mon_done;
        sb.push_back('{op: 6'd12, vcnt: 1, err: 1'b0});
        key_n[2] = 1'b0;
        cyc(2);
        sw_digit = 4'd5;
        key_n[0] = 1'b0;
        cyc(2);
        key_n[2] = 1'b1;
        cyc(4);
        key_n[2] = 1'b0;
        cyc(2);
        key_n[0] = 1'b1;
        cyc(10);
        key_n[2] = 1'b1;
        cyc(12);
        wait_done("busy keys", base);
        chk("busy keys echo", 32'(bcd_echo), 32'h12);
        chk("busy keys one conv", mon_rise, rise0 + 1);
        chk("busy keys one pulse", mon_vtot, vt0 + 1);

        // Reset in the middle of a conversion
        press(3);
        press_digit(4'd4);
        press_digit(4'd2);
        base = mon_done;
        vt0  = mon_vtot;
        sb.push_back('{op: '0, vcnt: 0, err: 1'b0});
        key_n[2] = 1'b0;
        t = 0;
        while (!busy && t < 30) begin
            cyc(1);
            t++;
        end
        if (!busy) begin
            n_chk++; n_fail++;
            $display("FAIL rst mid-conv: busy never rose");
        end
        rst_n = 1'b0;
        key_n[2] = 1'b1;
        cyc(1);
        chk("abort operand", 32'(operand), 0);
        chk("abort valid", 32'(operand_valid), 0);
        chk("abort echo", 32'(bcd_echo), 0);
        chk("abort neg", 32'(neg), 0);
        chk("abort err", 32'(entry_err), 0);
        chk("abort busy", 32'(busy), 0);
        rst_n = 1'b1;
        cyc(20);
        chk("abort no pulse", mon_vtot, vt0);
        wait_done("rst abort", base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
